// File: rtl/clk_gen_pkg.sv
// Shared constants for the clock-generator stages.
//   ds_width_gp     : width of the downsample value used by the divider and config interface
//   ds_reset_val_gp : downsample value in force after reset
//   ds_val_t        : convenience type for a downsample value of the default width
package clk_gen_pkg;

    localparam int ds_width_gp     = 8;
    localparam int ds_reset_val_gp = 0;

    typedef logic [ds_width_gp-1:0] ds_val_t;

endpackage

// File: rtl/clk_gen_ds_counter.sv
// Divide counter for the clock downsampler.
// Counts 0..ds_active_i and flips the output level each time it reaches
// ds_active_i, giving an output period of 2*(ds_active_i+1) clk_i cycles.
// Ports:
//   clk_i       : raw oscillator clock
//   reset_i     : synchronous active-high reset
//   en_i        : count enable; low holds counter and output level
//   ds_active_i : downsample value currently in force
//   toggle_o    : high in the cycle whose posedge will flip clk_o
//   clk_o       : divided clock level (registered)
module clk_gen_ds_counter
    import clk_gen_pkg::*;
#(
    parameter int width_p = ds_width_gp
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] ds_active_i,
    output logic               toggle_o,
    output logic               clk_o
);

    logic [width_p-1:0] cnt_r;

    // The active value only changes on a toggle, when the counter returns to 0,
    // so the equality compare is enough to keep cnt_r <= ds_active_i.
    assign toggle_o = en_i & (cnt_r == ds_active_i);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_r <= '0;
            clk_o <= 1'b0;
        end else if (toggle_o) begin
            cnt_r <= '0;
            clk_o <= ~clk_o;
        end else if (en_i) begin
            cnt_r <= cnt_r + width_p'(1);
        end
    end

endmodule

// File: rtl/clk_gen_downsampler.sv
// Programmable even divider for the ring-oscillator output.
// A new downsample value N is taken through a valid/ready handshake into a
// shadow register and moved into force only at the end of a full output
// period (clk_o falling), so the core never sees a runt pulse.
// Output period = 2*(N+1) clk_i cycles, 50% duty.
// Ports:
//   clk_i        : raw oscillator clock, the only clock
//   reset_i      : synchronous active-high reset, dominates all inputs
//   en_i         : count enable
//   ds_v_i       : new downsample value valid
//   ds_i         : new downsample value N
//   ds_ready_o   : a new value can be accepted
//   ds_pending_o : a value is accepted but not yet applied
//   ds_active_o  : downsample value currently in force
//   clk_o        : divided clock (registered)
module clk_gen_downsampler
    import clk_gen_pkg::*;
#(
    parameter int                 width_p     = ds_width_gp,
    parameter logic [width_p-1:0] reset_val_p = width_p'(ds_reset_val_gp)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic               ds_v_i,
    input  logic [width_p-1:0] ds_i,
    output logic               ds_ready_o,
    output logic               ds_pending_o,
    output logic [width_p-1:0] ds_active_o,
    output logic               clk_o
);

    logic [width_p-1:0] shadow_r;
    logic               toggle;
    logic               accept;
    logic               apply;

    clk_gen_ds_counter #(
        .width_p (width_p)
    ) u_cnt (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .en_i        (en_i),
        .ds_active_i (ds_active_o),
        .toggle_o    (toggle),
        .clk_o       (clk_o)
    );

    assign ds_ready_o = ~ds_pending_o;
    assign accept     = ds_v_i & ds_ready_o;
    // A toggle while clk_o is high is the 1->0 edge that closes a full period.
    assign apply      = toggle & clk_o & ds_pending_o;

    // NOTE: reset restores every register here; a pending value is discarded
    // rather than carried across reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shadow_r     <= '0;
            ds_active_o  <= reset_val_p;
            ds_pending_o <= 1'b0;
        end else if (accept) begin
            // accept and apply are exclusive: accept needs pending low, apply needs it high
            shadow_r     <= ds_i;
            ds_pending_o <= 1'b1;
        end else if (apply) begin
            ds_active_o  <= shadow_r;
            ds_pending_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_gen_downsampler.sv
// Self-checking bench for clk_gen_downsampler.
// A period-position model predicts the outputs for every driven cycle; the
// prediction is queued when the stimulus is applied and compared after the
// posedge that consumes it. Output periods are also measured between falls.
module tb_clk_gen_downsampler;
    import clk_gen_pkg::*;

    localparam int rv_c = 0;

    typedef struct {
        logic       clk;
        logic [7:0] act;
        logic       pend;
        logic       rdy;
    } exp_t;

    logic    clk_i = 1'b0;
    logic    reset_i = 1'b1;
    logic    en_i = 1'b0;
    logic    ds_v_i = 1'b0;
    ds_val_t ds_i = '0;
    logic    ds_ready_o;
    logic    ds_pending_o;
    ds_val_t ds_active_o;
    logic    clk_o;

    clk_gen_downsampler #(
        .width_p     (8),
        .reset_val_p (8'(rv_c))
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .en_i         (en_i),
        .ds_v_i       (ds_v_i),
        .ds_i         (ds_i),
        .ds_ready_o   (ds_ready_o),
        .ds_pending_o (ds_pending_o),
        .ds_active_o  (ds_active_o),
        .clk_o        (clk_o)
    );

    always #5 clk_i = ~clk_i;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // model state: position within the output period, active, shadow, pending
    int m_p    = 0;
    int m_act  = rv_c;
    int m_sh   = 0;
    bit m_pend = 1'b0;

    // fall-to-fall period measurement
    int   cyc         = 0;
    int   last_fall   = -1;
    int   last_period = 0;
    logic prev_clk    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus at the negedge and queue the predicted outputs.
    task automatic drive(input bit r, input bit e, input bit v, input int d);
        bit   acc;
        bit   wrap;
        exp_t x;
        @(negedge clk_i);
        reset_i = r;
        en_i    = e;
        ds_v_i  = v;
        ds_i    = 8'(d);
        if (r) begin
            m_p    = 0;
            m_act  = rv_c;
            m_sh   = 0;
            m_pend = 1'b0;
        end else begin
            acc  = v && !m_pend;
            wrap = 1'b0;
            if (e) begin
                m_p++;
                if (m_p == 2 * (m_act + 1)) begin
                    m_p  = 0;
                    wrap = 1'b1;
                end
            end
            if (acc) begin
                m_sh   = d;
                m_pend = 1'b1;
            end else if (wrap && m_pend) begin
                m_act  = m_sh;
                m_pend = 1'b0;
            end
        end
        x.clk  = (m_p >= m_act + 1);
        x.act  = 8'(m_act);
        x.pend = m_pend;
        x.rdy  = !m_pend;
        exp_q.push_back(x);
    endtask

    // Run enabled idle cycles until the model sits at position `pos` with value `act`.
    task automatic run_to(input int act, input int pos, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (m_act == act && m_p == pos) found = 1'b1;
            else drive(0, 1, 0, 0);
        end
        check(tag, 32'(found), 32'd1);
    endtask

    // Monitor: compare queued predictions just after each posedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("clk_o",        32'(clk_o),        32'(e.clk));
                check("ds_active_o",  32'(ds_active_o),  32'(e.act));
                check("ds_pending_o", 32'(ds_pending_o), 32'(e.pend));
                check("ds_ready_o",   32'(ds_ready_o),   32'(e.rdy));
            end
            cyc++;
            if (prev_clk && !clk_o) begin
                if (last_fall >= 0) last_period = cyc - last_fall;
                last_fall = cyc;
            end
            prev_clk = clk_o;
        end
    end

    initial begin
        // reset, then N = 0: clk_i/2
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, 1, 0, 0);
        check("period_ds0", 32'(last_period), 32'd2);

        // load 2, then a second request (5) while pending must be ignored
        drive(0, 1, 1, 2);
        drive(0, 1, 1, 5);
        for (int i = 0; i < 20; i++) drive(0, 1, 0, 0);
        check("period_ds2", 32'(last_period), 32'd6);
        check("active_ds2", 32'(ds_active_o), 32'd2);

        // load 3, freeze mid-high for 7 cycles; accept 4 while frozen
        drive(0, 1, 1, 3);
        run_to(3, 5, "wait_mid_high_ds3");
        drive(0, 0, 1, 4);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0);
        check("pending_frozen", 32'(ds_pending_o), 32'd1);
        check("active_frozen",  32'(ds_active_o),  32'd3);
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 0);

        // ds = 4: reset during the high phase with a value pending
        run_to(4, 6, "wait_mid_high_ds4");
        drive(0, 1, 1, 7);
        drive(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);

        // maximum value: period 512
        drive(0, 1, 1, 255);
        for (int i = 0; i < 1100; i++) drive(0, 1, 0, 0);
        check("period_ds255", 32'(last_period), 32'd512);
        check("active_ds255", 32'(ds_active_o), 32'd255);

        @(posedge clk_i);
        #2;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_gen_downsampler.md
Name: clk_gen_downsampler

Overview:
- Divides the raw ring-oscillator output of the clock generator by a programmable even ratio.
- Produces a 50% duty divided clock for the GCD core.
- Sits directly downstream of the inverter delay stages and the oscillator loop.
- Takes the oscillator output as its only clock.
- Divide ratio is reprogrammed through a valid/ready handshake. A new ratio takes effect only at a full-period boundary, so no runt pulses reach the core.

Parameters:
- width_p, 8: width of the downsample value and internal counter.
- reset_val_p, 0: downsample value loaded into the active register on reset.

Ports:
- clk_i, input, 1: raw oscillator clock; the only clock.
- reset_i, input, 1: synchronous, active-high reset.
- en_i, input, 1: count enable; low freezes counter and output level.
- ds_v_i, input, 1: new downsample value valid.
- ds_i, input, width_p: new downsample value N. Output period = 2*(N+1) clk_i cycles.
- ds_ready_o, output, 1: block can accept a new value.
- ds_pending_o, output, 1: a value is accepted but not yet applied.
- ds_active_o, output, width_p: downsample value currently in force.
- clk_o, output, 1: divided clock, registered.

Behaviour:
- All state is updated on posedge clk_i.
- Reset is synchronous and active-high. Reset dominates every other input in the same cycle.
- Reset values:
  - cnt_r = 0
  - clk_o = 0
  - ds_active_o = reset_val_p
  - shadow = 0
  - ds_pending_o = 0
  - ds_ready_o = 1
- ds_ready_o = ~ds_pending_o (combinational from state).
- Accept:
  - Occurs when ds_v_i & ds_ready_o at a posedge: shadow <= ds_i, pending <= 1.
  - ds_v_i while not ready is ignored; no state change.
  - No acceptance during reset.
- Counting, with en_i = 1:
  - If cnt_r == ds_active: cnt_r <= 0 and clk_o <= ~clk_o (a "toggle event").
  - Otherwise: cnt_r <= cnt_r + 1.
  - Counter never exceeds ds_active. Max ds_active = 2^width_p - 1, and the counter does not wrap past it.
- Apply:
  - Occurs only on a toggle event where clk_o goes 1 -> 0, i.e. the end of a full output period.
  - If pending at that event: ds_active <= shadow, pending <= 0.
  - The first period after apply uses the new value.
- Simultaneous events:
  - Accept and apply cannot coincide, because ready = 0 whenever pending = 1.
  - An apply and a new ds_v_i in the same cycle: ds_v_i is not accepted that cycle. ready rises the following cycle.
- en_i = 0:
  - cnt_r, clk_o and ds_active hold.
  - The handshake still accepts into shadow; the value is applied only after counting resumes and reaches the next 1 -> 0 edge.
- N = 0: clk_o toggles every cycle, giving clk_i/2.
- Latency:
  - clk_o first rises (N+1) cycles after reset deasserts (with en_i = 1).
  - ds_pending_o rises 1 cycle after acceptance.
- Reset mid-operation: returns to reset values on the next posedge, discarding any pending value. clk_o is forced to 0, which may shorten a high phase; this is acceptable only under reset.

Decomposition:
- Shared package clk_gen_pkg holds:
  - ds_width_gp = 8
  - ds_reset_val_gp = 0
  - these are shared with the other clock-generator stages and the config interface.
- One natural sub-module, clk_gen_ds_counter, contains cnt_r plus the compare and toggle logic. It outputs a toggle pulse and the clk_o level.
- The parent holds the shadow/active/pending registers and the handshake.

Test Plan:
- Reset then en_i = 1, ds_active = 0: clk_o = 0 at the first posedge after reset, toggles every cycle, period 2; ds_ready_o = 1, ds_pending_o = 0.
- Load ds_i = 2 while at ds = 0: ds_pending_o = 1 for at most one old period. After the next 1 -> 0 edge, clk_o is high for 3 and low for 3 cycles (period 6), ds_active_o = 2, ds_ready_o = 1.
- Second ds_v_i (ds_i = 5) while pending with value 2: ignored. ds_active_o becomes 2, never 5, and the shadow is unchanged.
- ds = 3 running; drop en_i for 7 cycles mid-high-phase: clk_o and the counter freeze. On resume, the remaining high cycles complete, giving a total high time of 4 counting cycles.
- ds = 4, assert reset_i for 1 cycle during the high phase with a value pending: next cycle clk_o = 0, ds_active_o = reset_val_p, ds_pending_o = 0, ds_ready_o = 1.
- ds_i = 255 (max): period 512 cycles, with the counter reaching 255 and returning to 0 without overflow.
